// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle of the PC unit: redirect/trap/halt controls in, fetch request and status out.
interface pc_next_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             stall;
  logic             fetch_ready;
  logic             is_compressed;
  logic             redir_valid;
  logic [XLEN-1:0]  redir_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_vector;
  logic             halt_req;
  logic             resume;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus_inc;
  logic             fetch_valid;
  logic             misalign_err;
  logic [XLEN-1:0]  misalign_addr;
  logic [CNT_W-1:0] fetch_count;
  logic [1:0]       state;

  // The PC unit drives the fetch request and its status.
  modport master (
    input  stall, fetch_ready, is_compressed, redir_valid, redir_target,
           trap_valid, trap_vector, halt_req, resume,
    output pc, pc_plus_inc, fetch_valid, misalign_err, misalign_addr,
           fetch_count, state
  );

  // Control logic and instruction memory see the opposite directions.
  modport slave (
    output stall, fetch_ready, is_compressed, redir_valid, redir_target,
           trap_valid, trap_vector, halt_req, resume,
    input  pc, pc_plus_inc, fetch_valid, misalign_err, misalign_addr,
           fetch_count, state
  );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter unit: holds the fetch PC, steps by 2/4 on accepted fetches,
// applies trap/branch redirects with alignment checking, and supports halt/resume.
module pc_next_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int              C_EXT        = 1,
  parameter int              CNT_W        = 32
) (
  input logic           clk,
  input logic           reset,
  pc_next_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  // Halfword targets are only legal when compressed instructions exist.
  function automatic logic target_misaligned(input logic [XLEN-1:0] target);
    return target[0] | ((C_EXT == 0) & target[1]);
  endfunction

  state_t           state_r, state_nxt_s;
  logic [XLEN-1:0]  pc_r, pc_nxt_s;
  logic             err_r, err_nxt_s;
  logic [XLEN-1:0]  addr_r, addr_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [XLEN-1:0]  step_s;
  logic [XLEN-1:0]  pc_plus_inc_s;
  logic             fetch_valid_s;
  logic             handshake_s;

  // Step size and sequential successor of the current pc.
  always_comb begin
    if ((C_EXT != 0) && bus.is_compressed) begin
      step_s = {{(XLEN-3){1'b0}}, 3'd2};
    end else begin
      step_s = {{(XLEN-3){1'b0}}, 3'd4};
    end
    pc_plus_inc_s = pc_r + step_s;
  end

  assign fetch_valid_s = (state_r == ST_RUN) & ~bus.stall;
  assign handshake_s   = fetch_valid_s & bus.fetch_ready;

  // Next-state, next-pc and error/counter updates by state and priority.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    err_nxt_s   = 1'b0;
    addr_nxt_s  = addr_r;
    cnt_nxt_s   = cnt_r;

    if (handshake_s) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end

    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (bus.trap_valid) begin
          pc_nxt_s = bus.trap_vector;
        end else if (bus.redir_valid) begin
          if (target_misaligned(bus.redir_target)) begin
            err_nxt_s   = 1'b1;
            addr_nxt_s  = bus.redir_target;
            state_nxt_s = ST_FAULT;
          end else begin
            pc_nxt_s = bus.redir_target;
          end
        end else if (bus.halt_req) begin
          state_nxt_s = ST_HALT;
        end else if (handshake_s) begin
          pc_nxt_s = pc_plus_inc_s;
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      ST_HALT: begin
        if (bus.trap_valid) begin
          pc_nxt_s    = bus.trap_vector;
          state_nxt_s = ST_RUN;
        end else if (bus.resume) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_FAULT: begin
        if (bus.trap_valid) begin
          pc_nxt_s    = bus.trap_vector;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // Architectural state registers; reset discards any in-flight handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_VECTOR;
      err_r   <= 1'b0;
      addr_r  <= {XLEN{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      err_r   <= err_nxt_s;
      addr_r  <= addr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign bus.pc            = pc_r;
  assign bus.pc_plus_inc   = pc_plus_inc_s;
  assign bus.fetch_valid   = fetch_valid_s;
  assign bus.misalign_err  = err_r;
  assign bus.misalign_addr = addr_r;
  assign bus.fetch_count   = cnt_r;
  assign bus.state         = state_r;

endmodule
